// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl_if
//  Description : Coordinate, button and ball inputs plus game-flow status
//                outputs of the game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_flow_ctrl_if;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        button_c;
    logic        button_u;
    logic        ball_lost;
    logic        end_of_frame;
    logic        action_tick;
    logic [1:0]  state;
    logic        splash_active;
    logic [1:0]  regime;
    logic [1:0]  lives;
    logic        game_over;

    modport master (
        output h_coord, v_coord, button_c, button_u, ball_lost,
        input  end_of_frame, action_tick, state, splash_active, regime, lives, game_over
    );

    modport slave (
        input  h_coord, v_coord, button_c, button_u, ball_lost,
        output end_of_frame, action_tick, state, splash_active, regime, lives, game_over
    );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl
//  Description : Frame strobe, button debounce, game-phase FSM, movement tick,
//                input-regime selection and lives counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int FRAMES_PER_ACTION = 3,
    parameter int SPLASH_FRAMES     = 180,
    parameter int DEBOUNCE_CYCLES   = 360000,
    parameter int LIVES             = 3,
    parameter int H_LAST            = 799,
    parameter int V_LAST            = 599
) (
    input  wire logic        pixel_clk,
    input  wire logic        rst_n,
    game_flow_ctrl_if.slave  bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FRAME_W = $clog2(SPLASH_FRAMES + 1);
    localparam int ACT_W   = $clog2(FRAMES_PER_ACTION + 1);

    typedef enum logic [1:0] {
        ST_SPLASH = 2'b00,
        ST_PLAY   = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic       w_press_c;
    logic       w_press_u;
    logic       w_match;
    logic       w_unused_hbit;

    assign w_raw         = {bus.button_u, bus.button_c};
    assign w_press_c     = w_press[0];
    assign w_press_u     = w_press[1];
    assign w_unused_hbit = bus.h_coord[10];
    assign w_match       = (bus.h_coord[9:0] == 10'(H_LAST)) && (bus.v_coord == 10'(V_LAST));

    // A press is only armed once the synchroniser has shown the button released,
    // so a button held through reset never yields a press.
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic            sync1_q, sync2_q, level_q, level_dly_q, armed_q, press_q;
        logic [1:0]      warm_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge pixel_clk) begin
            if (!rst_n) begin
                sync1_q     <= 1'b0;
                sync2_q     <= 1'b0;
                level_q     <= 1'b0;
                level_dly_q <= 1'b0;
                armed_q     <= 1'b0;
                press_q     <= 1'b0;
                warm_q      <= 2'b00;
                cnt_q       <= '0;
            end else begin
                sync1_q     <= w_raw[gi];
                sync2_q     <= sync1_q;
                warm_q      <= {warm_q[0], 1'b1};
                level_dly_q <= level_q;
                press_q     <= armed_q && level_q && !level_dly_q;
                if (warm_q[1] && !sync2_q) begin
                    armed_q <= 1'b1;
                end
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign w_press[gi] = press_q;
    end

    state_t             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [1:0]         regime_q, regime_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic               eof_q, eof_d;
    logic               tick_q, tick_d;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q  <= ST_SPLASH;
            lives_q  <= 2'(LIVES);
            regime_q <= 2'b11;
            frame_q  <= '0;
            act_q    <= '0;
            eof_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            regime_q <= regime_d;
            frame_q  <= frame_d;
            act_q    <= act_d;
            eof_q    <= eof_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        regime_d = regime_q;
        frame_d  = frame_q;
        act_d    = act_q;
        eof_d    = w_match;
        tick_d   = w_match && (state_q == ST_PLAY) && (act_q == '0);

        // Tick is taken from the raw match so it lines up with end_of_frame.
        if (w_match && (state_q == ST_PLAY)) begin
            act_d = (act_q == ACT_W'(FRAMES_PER_ACTION - 1)) ? '0 : act_q + ACT_W'(1);
        end

        case (state_q)
            ST_SPLASH: begin
                if (eof_q && (frame_q != FRAME_W'(SPLASH_FRAMES))) begin
                    frame_d = frame_q + FRAME_W'(1);
                    if (frame_q == FRAME_W'(SPLASH_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                        lives_d = 2'(LIVES);
                        act_d   = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.ball_lost) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = ST_OVER;
                    end
                end else if (w_press_u) begin
                    state_d = ST_PAUSE;
                end
                if (w_press_c) begin
                    regime_d = {regime_q[1], ~regime_q[0]};
                end
            end
            ST_PAUSE: begin
                if (w_press_u) begin
                    state_d = ST_PLAY;
                end
                if (w_press_c) begin
                    regime_d = {regime_q[1], ~regime_q[0]};
                end
            end
            ST_OVER: begin
                if (w_press_c) begin
                    state_d = ST_SPLASH;
                    frame_d = '0;
                end
            end
            default: state_d = ST_SPLASH;
        endcase
    end

    assign bus.end_of_frame  = eof_q;
    assign bus.action_tick   = tick_q;
    assign bus.state         = state_q;
    assign bus.splash_active = (state_q == ST_SPLASH);
    assign bus.game_over     = (state_q == ST_OVER);
    assign bus.regime        = regime_q;
    assign bus.lives         = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_ctrl
//  Description : Directed bench for game_flow_ctrl with small parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;
    localparam int SF  = 2;
    localparam int FPA = 3;
    localparam int DB  = 4;
    localparam int LV  = 3;

    localparam logic [1:0] OP_BL = 2'd0;
    localparam logic [1:0] OP_PU = 2'd1;
    localparam logic [1:0] OP_PC = 2'd2;
    localparam logic [1:0] OP_FR = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [1:0] exp_state;
        logic [1:0] exp_lives;
        logic [1:0] exp_regime;
    } vec_t;

    logic pixel_clk = 1'b0;
    logic rst_n     = 1'b0;
    int   checks    = 0;
    int   errors    = 0;
    vec_t vecs[10];

    game_flow_ctrl_if bus();

    game_flow_ctrl #(
        .FRAMES_PER_ACTION(FPA),
        .SPLASH_FRAMES    (SF),
        .DEBOUNCE_CYCLES  (DB),
        .LIVES            (LV),
        .H_LAST           (799),
        .V_LAST           (599)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic chk_status(input string nm, input logic [1:0] st, input logic [1:0] lv,
                              input logic [1:0] rg);
        chk({nm, " state"}, bus.state, st);
        chk({nm, " lives"}, bus.lives, lv);
        chk({nm, " regime"}, bus.regime, rg);
        chk({nm, " splash"}, bus.splash_active, st == 2'b00);
        chk({nm, " over"}, bus.game_over, st == 2'b11);
    endtask

    // One coordinate match; eof and tick are checked the cycle after it.
    task automatic frame(input string nm, input logic exp_tick, input logic [10:0] h = 11'd799);
        bus.h_coord = h;
        bus.v_coord = 10'd599;
        cyc();
        chk({nm, " eof"}, bus.end_of_frame, 1'b1);
        chk({nm, " tick"}, bus.action_tick, exp_tick);
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
        cyc();
    endtask

    task automatic press(input logic u, input logic c);
        bus.button_u = u;
        bus.button_c = c;
        cyc(10);
        bus.button_u = 1'b0;
        bus.button_c = 1'b0;
        cyc(10);
    endtask

    task automatic lose_ball();
        bus.ball_lost = 1'b1;
        cyc();
        bus.ball_lost = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{OP_BL, 2'b01, 2'd2, 2'b11};
        vecs[1] = '{OP_BL, 2'b01, 2'd1, 2'b11};
        vecs[2] = '{OP_BL, 2'b11, 2'd0, 2'b11};
        vecs[3] = '{OP_BL, 2'b11, 2'd0, 2'b11};
        vecs[4] = '{OP_PU, 2'b11, 2'd0, 2'b11};
        vecs[5] = '{OP_PC, 2'b00, 2'd0, 2'b11};
        vecs[6] = '{OP_FR, 2'b00, 2'd0, 2'b11};
        vecs[7] = '{OP_FR, 2'b01, 2'd3, 2'b11};
        vecs[8] = '{OP_PC, 2'b01, 2'd3, 2'b10};
        vecs[9] = '{OP_PC, 2'b01, 2'd3, 2'b11};

        bus.h_coord   = 11'd0;
        bus.v_coord   = 10'd0;
        bus.button_c  = 1'b0;
        bus.button_u  = 1'b0;
        bus.ball_lost = 1'b0;
        rst_n         = 1'b0;
        cyc(3);
        chk_status("reset", 2'b00, 2'd3, 2'b11);
        chk("reset eof", bus.end_of_frame, 1'b0);
        chk("reset tick", bus.action_tick, 1'b0);
        rst_n = 1'b1;
        cyc(2);

        // Splash: PLAY follows the edge after the second end_of_frame.
        frame("splash1", 1'b0);
        chk("splash1 state", bus.state, 2'b00);
        bus.h_coord = 11'd799;
        bus.v_coord = 10'd599;
        cyc();
        chk("splash2 eof", bus.end_of_frame, 1'b1);
        chk("splash2 still splash", bus.state, 2'b00);
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
        cyc();
        chk_status("play entry", 2'b01, 2'd3, 2'b11);

        for (int f = 1; f <= 7; f++) begin
            frame($sformatf("cadence f%0d", f), (f % 3) == 1);
        end

        bus.button_u = 1'b1;
        cyc(3);
        bus.button_u = 1'b0;
        cyc(12);
        chk("glitch no pause", bus.state, 2'b01);

        bus.button_u = 1'b1;
        cyc(7);
        chk("press t+7 state", bus.state, 2'b01);
        cyc();
        chk("press t+8 state", bus.state, 2'b10);
        cyc(2);
        bus.button_u = 1'b0;
        cyc(12);

        frame("pause h-msb", 1'b0, 11'h71F);
        bus.h_coord = 11'd799;
        bus.v_coord = 10'd598;
        cyc();
        chk("row miss eof", bus.end_of_frame, 1'b0);
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
        cyc();

        press(1'b1, 1'b0);
        chk("resume state", bus.state, 2'b01);
        // Counter was 1 after seven frames, so the tick reappears on the third.
        frame("phase f8", 1'b0);
        frame("phase f9", 1'b0);
        frame("phase f10", 1'b1);

        for (int i = 0; i < 10; i++) begin
            case (vecs[i].op)
                OP_BL:   lose_ball();
                OP_PU:   press(1'b1, 1'b0);
                OP_PC:   press(1'b0, 1'b1);
                default: frame($sformatf("vec%0d", i), 1'b0);
            endcase
            chk_status($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_lives,
                       vecs[i].exp_regime);
        end

        // ball_lost arrives in the same cycle as the debounced press.
        bus.button_u = 1'b1;
        cyc(7);
        bus.ball_lost = 1'b1;
        cyc();
        bus.ball_lost = 1'b0;
        chk_status("collide u", 2'b01, 2'd2, 2'b11);
        cyc(2);
        bus.button_u = 1'b0;
        cyc(12);
        chk("collide u discarded", bus.state, 2'b01);

        bus.button_u = 1'b1;
        bus.button_c = 1'b1;
        cyc(7);
        bus.ball_lost = 1'b1;
        cyc();
        bus.ball_lost = 1'b0;
        chk_status("collide uc", 2'b01, 2'd1, 2'b10);
        cyc(2);
        bus.button_u = 1'b0;
        bus.button_c = 1'b0;
        cyc(12);

        press(1'b1, 1'b0);
        chk("pause before reset", bus.state, 2'b10);
        bus.button_u = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        cyc(3);
        chk_status("mid reset", 2'b00, 2'd3, 2'b11);
        chk("mid reset eof", bus.end_of_frame, 1'b0);
        chk("mid reset tick", bus.action_tick, 1'b0);
        rst_n       = 1'b1;
        bus.h_coord = 11'd799;
        bus.v_coord = 10'd599;
        cyc();
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
        cyc();
        bus.h_coord = 11'd799;
        bus.v_coord = 10'd599;
        cyc();
        bus.h_coord = 11'd0;
        bus.v_coord = 10'd0;
        cyc();
        chk("post reset play", bus.state, 2'b01);
        cyc(10);
        chk("held no press", bus.state, 2'b01);
        bus.button_u = 1'b0;
        cyc(12);
        press(1'b1, 1'b0);
        chk("re-press pause", bus.state, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
